layer_tmux: RTL and testbench
=============================

// Module: layer_tmux
// PURPOSE
//  Time-multiplexed fully-connected layer: out[i] = act(sat((b[i]<<FRAC_BITS + sum_j x[j]*w[i][j]) >>> FRAC_BITS)).
//  Successor to the combinational Layer, intended for wide layers.
//  NUM_PE MAC units are shared across OUT_N neurons, consuming one input element per cycle.
//  Uses valid/ready handshakes on both sides, saturating output and a selectable ReLU.
//  Sits between layer stages in the NPU datapath.
// PARAMETERS
//  IN_N       4   input vector length
//  OUT_N      4   output neurons; OUT_N % NUM_PE == 0 required
//  NUM_PE     2   parallel MAC units; G = OUT_N/NUM_PE neuron groups
//  DATA_WIDTH 8   signed element width for x, w, b and y
//  ACC_WIDTH  24  signed accumulator width; no wrap within the specified input ranges
//  FRAC_BITS  0   fixed-point fraction bits of x and w
// PORTS
//  clk        in   1                       clock, rising edge
//  rst_n      in   1                       asynchronous active-low reset
//  in_valid   in   1                       input bundle valid
//  in_ready   out  1                       block can accept a bundle
//  relu_en    in   1                       1: clamp negative results to 0; sampled at accept
//  in_vec     in   IN_N*DATA_WIDTH         x[j] at [j*DW +: DW]
//  weights    in   OUT_N*IN_N*DATA_WIDTH   w[i][j] at [(i*IN_N+j)*DW +: DW]
//  biases     in   OUT_N*DATA_WIDTH        b[i] at [i*DW +: DW]
//  out_valid  out  1                       out_vec holds a complete result
//  out_ready  in   1                       consumer accepts result
//  out_vec    out  OUT_N*DATA_WIDTH        y[i] at [i*DW +: DW]
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0; out_vec=0; counters and accumulators 0; in_ready=1 after reset.
//  Asserting rst_n low mid-operation aborts the operation and discards all data.
//  FSM states: IDLE, BUSY, DONE. in_ready = (IDLE) | (DONE & out_ready).
//  Accept occurs when in_valid & in_ready on a rising edge:
//   - register in_vec, weights, biases and relu_en;
//   - set g=0 and j=0;
//   - load acc[p] = sext(b[p]) << FRAC_BITS;
//   - go to BUSY.
//  BUSY, each cycle:
//   - acc[p] += x[j]*w[g*NUM_PE+p][j] for each p, using a full 2*DW signed product sign-extended to ACC_WIDTH;
//   - j increments.
//  BUSY, when j == IN_N-1:
//   - neuron g*NUM_PE+p is finalised into the out_vec register;
//   - j wraps to 0 and g increments;
//   - acc reloads with the next group's biases.
//  BUSY, when j == IN_N-1 and g == G-1: go to DONE and set out_valid=1.
//  Finalise:
//   - r = acc >>> FRAC_BITS (arithmetic shift);
//   - saturate r to [-2^(DW-1), 2^(DW-1)-1];
//   - if relu_en and r < 0, r = 0.
//  Latency: exactly IN_N*G cycles from the accept edge to the edge that sets out_valid.
//  DONE:
//   - out_vec and out_valid are held stable while out_ready=0;
//   - on out_ready, out_valid clears and the state goes to IDLE;
//   - if in_valid is also high, the new bundle is accepted on the same edge and the state goes to BUSY (back-to-back, no bubble).
//  in_vec, weights and biases are don't-care outside accept cycles.
//  out_vec keeps its last value after hand-off; it is not cleared.
//  Partially written out_vec during BUSY is not valid.
// TESTING (defaults, FRAC_BITS=0)
//  1. Basic: x={1,2,3,4}, all w=1, b={0,1,-1,5}, relu_en=0
//     -> y={10,11,9,15}; out_valid 8 cycles after accept.
//  2. Saturation: all x=127, all w=127, b=0 -> y=127 all.
//     With w=-128 -> y=-128 all.
//  3. ReLU: x={1,0,0,0}, w[i][0]=-5, b=0:
//     relu_en=0 -> y=-5 all; relu_en=1 -> y=0 all.
//  4. Backpressure: hold out_ready=0 for 5 cycles after out_valid
//     -> out_vec stable, in_ready=0, in_valid ignored; release -> handshake in 1 cycle.
//  5. Back-to-back: in_valid held high with a second bundle while out_ready=1
//     -> second accept on the same edge as the first output hand-off; second result 8 cycles later.
//  6. Reset mid-BUSY: assert rst_n=0 at j=2, g=1
//     -> out_valid=0 and out_vec=0 immediately; in_ready=1 after release; next bundle computes correctly.

Source files
------------

// File: rtl/layer_tmux.sv
// layer_tmux: time-multiplexed fully-connected layer with shared MACs, saturation and optional ReLU
module layer_tmux #(
  parameter int IN_N       = 4,
  parameter int OUT_N      = 4,
  parameter int NUM_PE     = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int FRAC_BITS  = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                relu_en,
  input  logic [IN_N*DATA_WIDTH-1:0]          in_vec,
  input  logic [OUT_N*IN_N*DATA_WIDTH-1:0]    weights,
  input  logic [OUT_N*DATA_WIDTH-1:0]         biases,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_N*DATA_WIDTH-1:0]         out_vec
);
  localparam int G  = OUT_N / NUM_PE;
  localparam int JW = IN_N > 1 ? $clog2(IN_N) : 1;
  localparam int GW = G > 1 ? $clog2(G) : 1;
  localparam int DW = DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMIN = -SMAX - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;
  logic [JW-1:0] j_q;
  logic [GW-1:0] g_q, gn;
  logic relu_q, accept, last_j, last_g;
  logic signed [DW-1:0] x_q [IN_N];
  logic signed [DW-1:0] w_q [G][NUM_PE][IN_N];
  logic signed [DW-1:0] b_q [G][NUM_PE];
  logic signed [DW-1:0] y_q [G][NUM_PE];
  logic signed [ACC_WIDTH-1:0] acc_q [NUM_PE];
  logic signed [2*DW-1:0] prod [NUM_PE];
  logic signed [ACC_WIDTH-1:0] sum [NUM_PE];
  logic signed [ACC_WIDTH-1:0] r [NUM_PE];
  logic signed [ACC_WIDTH-1:0] rld [NUM_PE];
  logic signed [DW-1:0] fin [NUM_PE];

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = state_q == DONE;
  assign accept    = in_valid & in_ready;
  assign last_j    = j_q == JW'(IN_N - 1);
  assign last_g    = g_q == GW'(G - 1);
  assign gn        = last_g ? '0 : g_q + 1'b1;

  for (genvar a = 0; a < G; a++) begin : g_out
    for (genvar b = 0; b < NUM_PE; b++) begin : g_pe
      assign out_vec[(a*NUM_PE+b)*DW +: DW] = y_q[a][b];
    end
  end

  // Next state: accept wins in DONE so a waiting bundle follows the hand-off without a bubble
  always_comb begin
    state_d = accept ? BUSY
            : (state_q == BUSY && last_j && last_g) ? DONE
            : (state_q == DONE && out_ready) ? IDLE
            : state_q;
  end

  // Per-PE MAC sum, finalisation of the last term and next-group bias reload value
  always_comb begin
    for (int p = 0; p < NUM_PE; p++) begin
      prod[p] = x_q[j_q] * w_q[g_q][p][j_q];
      sum[p]  = acc_q[p] + ACC_WIDTH'(prod[p]);
      r[p]    = sum[p] >>> FRAC_BITS;
      fin[p]  = (relu_q && r[p] < 0) ? '0
              : r[p] > SMAX ? SMAX[DW-1:0]
              : r[p] < SMIN ? SMIN[DW-1:0]
              : r[p][DW-1:0];
      rld[p]  = ACC_WIDTH'(b_q[gn][p]) <<< FRAC_BITS;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, counters, accumulators and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q    <= '0;
      g_q    <= '0;
      relu_q <= 1'b0;
      for (int j = 0; j < IN_N; j++) x_q[j] <= '0;
      for (int p = 0; p < NUM_PE; p++) acc_q[p] <= '0;
      for (int g = 0; g < G; g++)
        for (int p = 0; p < NUM_PE; p++) begin
          b_q[g][p] <= '0;
          y_q[g][p] <= '0;
          for (int j = 0; j < IN_N; j++) w_q[g][p][j] <= '0;
        end
    end else if (accept) begin
      j_q    <= '0;
      g_q    <= '0;
      relu_q <= relu_en;
      for (int j = 0; j < IN_N; j++) x_q[j] <= in_vec[j*DW +: DW];
      for (int p = 0; p < NUM_PE; p++)
        acc_q[p] <= ACC_WIDTH'(signed'(biases[p*DW +: DW])) <<< FRAC_BITS;
      for (int g = 0; g < G; g++)
        for (int p = 0; p < NUM_PE; p++) begin
          b_q[g][p] <= biases[(g*NUM_PE+p)*DW +: DW];
          for (int j = 0; j < IN_N; j++)
            w_q[g][p][j] <= weights[((g*NUM_PE+p)*IN_N+j)*DW +: DW];
        end
    end else if (state_q == BUSY) begin
      j_q <= last_j ? '0 : j_q + 1'b1;
      if (last_j) g_q <= gn;
      for (int p = 0; p < NUM_PE; p++) begin
        acc_q[p] <= last_j ? rld[p] : sum[p];
        if (last_j) y_q[g_q][p] <= fin[p];
      end
    end
  end
endmodule

// File: tb/tb_layer_tmux.sv
// tb_layer_tmux: randomized and directed checks of layer_tmux against a sum-of-products reference
module tb_layer_tmux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic relu_en = 1'b0;
  logic [31:0] in_vec = '0;
  logic [127:0] weights = '0;
  logic [31:0] biases = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_vec;
  int tests = 0;
  int fails = 0;

  layer_tmux dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .relu_en(relu_en), .in_vec(in_vec), .weights(weights), .biases(biases),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [31:0] x, logic [127:0] w, logic [31:0] b, logic relu);
    logic [31:0] y;
    int s;
    y = '0;
    for (int i = 0; i < 4; i++) begin
      s = $signed(b[i*8 +: 8]);
      for (int j = 0; j < 4; j++) s += $signed(x[j*8 +: 8]) * $signed(w[(i*4+j)*8 +: 8]);
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      if (relu && s < 0) s = 0;
      y[i*8 +: 8] = 8'(s);
    end
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [127:0] w, input logic [31:0] b, input logic relu);
    int n;
    in_vec = x; weights = w; biases = b; relu_en = relu; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (out_vec !== 32'h0) begin fails++; $display("FAIL reset_out_vec got %h want 0", out_vec); end
  endtask

  task automatic test_basic();
    int lat;
    send(32'h04030201, {16{8'd1}}, 32'h05FF0100, 1'b0);
    wait_valid(lat);
    tests++; if (lat != 8) begin fails++; $display("FAIL basic_latency got %0d want 8", lat); end
    tests++; if (out_vec !== 32'h0F090B0A) begin fails++; $display("FAIL basic_out got %h want 0f090b0a", out_vec); end
    take();
  endtask

  task automatic test_saturation();
    int lat;
    send({4{8'd127}}, {16{8'd127}}, 32'h0, 1'b0);
    wait_valid(lat);
    tests++; if (out_vec !== 32'h7F7F7F7F) begin fails++; $display("FAIL sat_pos got %h want 7f7f7f7f", out_vec); end
    take();
    send({4{8'd127}}, {16{8'h80}}, 32'h0, 1'b0);
    wait_valid(lat);
    tests++; if (out_vec !== 32'h80808080) begin fails++; $display("FAIL sat_neg got %h want 80808080", out_vec); end
    take();
  endtask

  task automatic test_relu();
    int lat;
    send(32'h00000001, {4{32'h000000FB}}, 32'h0, 1'b0);
    wait_valid(lat);
    tests++; if (out_vec !== 32'hFBFBFBFB) begin fails++; $display("FAIL relu_off got %h want fbfbfbfb", out_vec); end
    take();
    send(32'h00000001, {4{32'h000000FB}}, 32'h0, 1'b1);
    wait_valid(lat);
    tests++; if (out_vec !== 32'h0) begin fails++; $display("FAIL relu_on got %h want 0", out_vec); end
    take();
  endtask

  task automatic test_random();
    logic [31:0] x, b, e;
    logic [127:0] w;
    logic relu;
    int lat;
    for (int k = 0; k < 24; k++) begin
      x = $urandom; b = $urandom; w = {$urandom, $urandom, $urandom, $urandom};
      relu = 1'($urandom_range(0, 1));
      e = model(x, w, b, relu);
      send(x, w, b, relu);
      wait_valid(lat);
      tests++; if (lat != 8) begin fails++; $display("FAIL rand_latency[%0d] got %0d want 8", k, lat); end
      tests++; if (out_vec !== e) begin fails++; $display("FAIL rand_out[%0d] got %h want %h", k, out_vec, e); end
      take();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x, b, e, e2;
    logic [127:0] w;
    int lat;
    x = $urandom; b = $urandom; w = {$urandom, $urandom, $urandom, $urandom};
    e = model(x, w, b, 1'b0);
    send(x, w, b, 1'b0);
    wait_valid(lat);
    in_vec = ~x; weights = ~w; biases = ~b; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %0b want 0", c, in_ready); end
      tests++; if (out_valid !== 1'b1 || out_vec !== e) begin fails++; $display("FAIL bp_hold[%0d] got v=%0b %h want v=1 %h", c, out_valid, out_vec, e); end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
    tick();
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || out_vec !== e) begin fails++; $display("FAIL bp_handoff got v=%0b %h want v=0 %h", out_valid, out_vec, e); end
    e2 = model(32'h01010101, {16{8'd2}}, 32'h0, 1'b0);
    send(32'h01010101, {16{8'd2}}, 32'h0, 1'b0);
    wait_valid(lat);
    tests++; if (out_vec !== e2) begin fails++; $display("FAIL bp_after got %h want %h", out_vec, e2); end
    take();
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa, ba, xb, bb, ea, eb;
    logic [127:0] wa, wb;
    int lat;
    xa = $urandom; ba = $urandom; wa = {$urandom, $urandom, $urandom, $urandom};
    xb = $urandom; bb = $urandom; wb = {$urandom, $urandom, $urandom, $urandom};
    ea = model(xa, wa, ba, 1'b1);
    eb = model(xb, wb, bb, 1'b0);
    send(xa, wa, ba, 1'b1);
    wait_valid(lat);
    tests++; if (out_vec !== ea) begin fails++; $display("FAIL b2b_first got %h want %h", out_vec, ea); end
    in_vec = xb; weights = wb; biases = bb; relu_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_handoff got %0b want 0", out_valid); end
    wait_valid(lat);
    tests++; if (lat != 8) begin fails++; $display("FAIL b2b_latency got %0d want 8", lat); end
    tests++; if (out_vec !== eb) begin fails++; $display("FAIL b2b_second got %h want %h", out_vec, eb); end
    take();
  endtask

  task automatic test_mid_reset();
    logic [31:0] x, b, e;
    logic [127:0] w;
    int lat;
    send(32'h7F7F7F7F, {16{8'd3}}, 32'h11223344, 1'b0);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid got %0b want 0", out_valid); end
    tests++; if (out_vec !== 32'h0) begin fails++; $display("FAIL mrst_out got %h want 0", out_vec); end
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mrst_ready got %0b want 1", in_ready); end
    x = $urandom; b = $urandom; w = {$urandom, $urandom, $urandom, $urandom};
    e = model(x, w, b, 1'b0);
    send(x, w, b, 1'b0);
    wait_valid(lat);
    tests++; if (lat != 8) begin fails++; $display("FAIL mrst_latency got %0d want 8", lat); end
    tests++; if (out_vec !== e) begin fails++; $display("FAIL mrst_next got %h want %h", out_vec, e); end
    take();
  endtask

  initial begin
    repeat (2) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_saturation();
    test_relu();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
